// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // A request is bad if it is not word aligned or falls past the last word.
    function automatic logic dmem_addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM: synchronous byte-enabled write, asynchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder with fixed latency, byte-enabled stores
// and alignment/range error reporting; drives the pipeline stall.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    input  logic [BE_W-1:0]   req_be_i,
    output logic              rsp_valid_o,
    output logic [WORD_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              stall_o
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept, enter_resp;

    logic              we_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              op_we, op_err;
    logic [31:0]       op_addr;
    logic [WORD_W-1:0] op_wdata;
    logic [BE_W-1:0]   op_be;
    logic [WORD_W-1:0] mem_rdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    cnt_d  = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
        end
    end

    // With LATENCY==1 the access completes on the accepting edge itself,
    // before the latches hold anything, so IDLE uses the live request.
    assign op_we    = (state_q == IDLE) ? req_we_i    : we_q;
    assign op_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
    assign op_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
    assign op_be    = (state_q == IDLE) ? req_be_i    : be_q;
    assign op_err   = dmem_addr_err(op_addr, DEPTH_WORDS);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk_i),
        .we   (enter_resp & op_we & ~op_err),
        .be   (op_be),
        .addr (op_addr[AW+1:2]),
        .wdata(op_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_err_o <= enter_resp & op_err;
            if (enter_resp) begin
                if (op_err)      rsp_rdata_o <= '0;
                else if (!op_we) rsp_rdata_o <= mem_rdata;
            end
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign stall_o     = ((state_q == IDLE) & req_valid_i) | (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance 0 runs LATENCY=3, instance 1 runs LATENCY=1.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        stall     [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(256),
            .LATENCY    ((g == 0) ? 3 : 1)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .req_valid_i(req_valid[g]),
            .req_ready_o(req_ready[g]),
            .req_we_i   (req_we[g]),
            .req_addr_i (req_addr[g]),
            .req_wdata_i(req_wdata[g]),
            .req_be_i   (req_be[g]),
            .rsp_valid_o(rsp_valid[g]),
            .rsp_rdata_o(rsp_rdata[g]),
            .rsp_err_o  (rsp_err[g]),
            .stall_o    (stall[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current (post-edge) time, collect the response
    // and confirm the response strobe lasts exactly one cycle.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rdata, output logic err,
                       output int stalls, output int lat);
        bit got;
        got = 0; stalls = 0; lat = -1; rdata = '0; err = 1'b0;
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; req_be[d] = be;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (stall[d]) stalls++;
            if (rsp_valid[d]) begin
                got = 1; lat = c; rdata = rsp_rdata[d]; err = rsp_err[d];
            end
            @(posedge clk); #1;
            req_valid[d] = 1'b0;
        end
        chk("response_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk("after_resp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("after_resp_err", 32'(rsp_err[d]), 32'd0);
        chk("after_resp_ready", 32'(req_ready[d]), 32'd1);
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          st, lt;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   req_be[d] = '0;
        end
        @(negedge clk);
        chk("rst_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rdata", rsp_rdata[0], 32'd0);
        chk("rst_err", 32'(rsp_err[0]), 32'd0);
        chk("rst_stall", 32'(stall[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Store then load, LATENCY=3
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, st, lt);
        chk("st10_stall", 32'(st), 32'd3);
        chk("st10_lat", 32'(lt), 32'd3);
        chk("st10_err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, st, lt);
        chk("ld10_data", rd, 32'hDEADBEEF);
        chk("ld10_lat", 32'(lt), 32'd3);
        chk("ld10_err", 32'(er), 32'd0);

        // Byte enables
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, st, lt);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, st, lt);
        chk("st20_be_err", 32'(er), 32'd0);
        chk("st20_rdata_hold", rd, 32'hDEADBEEF);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, st, lt);
        chk("ld20_merged", rd, 32'h11BB33DD);
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, st, lt);
        chk("st20_be0_err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, st, lt);
        chk("ld20_after_be0", rd, 32'h11BB33DD);

        // Errors
        txn(0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, st, lt);
        chk("ld22_err", 32'(er), 32'd1);
        chk("ld22_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, st, lt);
        txn(0, 1'b1, 32'h400, 32'h55555555, 4'hF, rd, er, st, lt);
        chk("st400_err", 32'(er), 32'd1);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, st, lt);
        chk("ld0_unchanged", rd, 32'hCAFEF00D);
        chk("ld0_err", 32'(er), 32'd0);

        // LATENCY=1: prefill, then back-to-back loads with valid held high
        txn(1, 1'b1, 32'h0, 32'h0A0A0A0A, 4'hF, rd, er, st, lt);
        chk("l1_st_lat", 32'(lt), 32'd1);
        chk("l1_st_stall", 32'(st), 32'd1);
        txn(1, 1'b1, 32'h4, 32'h0B0B0B0B, 4'hF, rd, er, st, lt);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0;
        @(negedge clk);
        chk("b2b_c0_ready", 32'(req_ready[1]), 32'd1);
        chk("b2b_c0_stall", 32'(stall[1]), 32'd1);
        @(posedge clk); #1;
        req_addr[1] = 32'h4;
        @(negedge clk);
        chk("b2b_c1_valid", 32'(rsp_valid[1]), 32'd1);
        chk("b2b_c1_ready", 32'(req_ready[1]), 32'd0);
        chk("b2b_c1_stall", 32'(stall[1]), 32'd0);
        chk("b2b_c1_rdata", rsp_rdata[1], 32'h0A0A0A0A);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_c2_valid", 32'(rsp_valid[1]), 32'd0);
        chk("b2b_c2_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("b2b_c3_valid", 32'(rsp_valid[1]), 32'd1);
        chk("b2b_c3_ready", 32'(req_ready[1]), 32'd0);
        chk("b2b_c3_rdata", rsp_rdata[1], 32'h0B0B0B0B);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_c4_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk); #1;

        // Reset mid-operation drops an in-flight store
        txn(0, 1'b1, 32'h8, 32'h0, 4'hF, rd, er, st, lt);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, st, lt);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h8;
        req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("mid_wait_ready", 32'(req_ready[0]), 32'd0);
        chk("mid_wait_stall", 32'(stall[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready[0]), 32'd1);
        chk("mid_rst_stall", 32'(stall[0]), 32'd0);
        chk("mid_rst_rdata", rsp_rdata[0], 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        @(posedge clk); #1;
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, st, lt);
        chk("ld8_not_committed", rd, 32'd0);
        chk("ld8_err", 32'(er), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
